// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between N_REQ pixel readers.
// Latency: grant is combinational; the response follows 2 cycles after the grant.
// Backpressure: a request stays pending until granted; en=0 blocks new grants while in-flight reads drain.
module sprite_rom_arbiter #(
    parameter int                 N_REQ      = 4,
    parameter int                 ADDR_W     = 19,
    parameter int                 DATA_W     = 24,
    parameter logic [DATA_W-1:0]  TRANSP_KEY = 24'hFF00FF
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    output logic [N_REQ-1:0]          grant,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      rsp_valid,
    output logic [2:0]                rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_transp
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]     r_ptr;
    logic              r_s1_vld;
    logic [PW-1:0]     r_s1_id;
    logic              r_rsp_vld;
    logic [PW-1:0]     r_rsp_id;
    logic [DATA_W-1:0] r_rsp_dat;

    logic              w_found;
    logic              w_acc;
    logic [PW-1:0]     w_win;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_idx;

    // Scan upward from r_ptr, wrapping modulo N_REQ; first pending requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            w_idx = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ)) : PW'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Reset gates the accept so grant/rom_addr stay quiet while Reset_n is low.
    assign w_acc = Reset_n & en & w_found;

    always_comb begin
        grant    = '0;
        rom_addr = '0;
        if (w_acc) begin
            grant[w_win] = 1'b1;
            rom_addr     = req_addr[w_win*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_id   <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= '0;
            r_rsp_dat <= '0;
        end else begin
            if (w_acc) begin
                r_ptr   <= (w_win == PW'(N_REQ-1)) ? '0 : w_win + 1'b1;
                r_s1_id <= w_win;
            end
            r_s1_vld  <= w_acc;
            r_rsp_vld <= r_s1_vld;
            // ROM data is valid in the cycle after the grant, aligned with stage 1.
            if (r_s1_vld) begin
                r_rsp_id  <= r_s1_id;
                r_rsp_dat <= rom_data;
            end
        end
    end

    assign rsp_valid  = r_rsp_vld;
    assign rsp_id     = 3'(r_rsp_id);
    assign rsp_data   = r_rsp_dat;
    assign rsp_transp = r_rsp_vld && (r_rsp_dat == TRANSP_KEY);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a 1-cycle registered ROM model.
module tb_sprite_rom_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        en;
    logic [3:0]  req;
    logic [75:0] req_addr;
    logic [3:0]  grant;
    logic [18:0] rom_addr;
    logic [23:0] rom_data;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [23:0] rsp_data;
    logic        rsp_transp;

    int n_chk  = 0;
    int n_fail = 0;

    sprite_rom_arbiter dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .en         (en),
        .req        (req),
        .req_addr   (req_addr),
        .grant      (grant),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_transp (rsp_transp)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] exp_pix(input logic [18:0] a);
        if (a == 19'd5)      return 24'h123456;
        else if (a == 19'd9) return 24'hFF00FF;
        else                 return {8'h40, a[7:0], ~a[7:0]};
    endfunction

    always @(posedge Clk) rom_data <= exp_pix(rom_addr);

    task automatic do_reset();
        Reset_n = 1'b0;
        en      = 1'b1;
        req     = 4'b0000;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n  = 1'b0;
        en       = 1'b1;
        req      = 4'b1111;
        req_addr = {19'd7, 19'd6, 19'd5, 19'd4};
        repeat (2) @(negedge Clk);
        #1;
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b need 0000", grant); end
        n_chk++; if (rom_addr !== 19'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d need 0", rom_addr); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
        n_chk++; if (rsp_id !== 3'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d need 0", rsp_id); end
        n_chk++; if (rsp_data !== 24'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h need 0", rsp_data); end
        n_chk++; if (rsp_transp !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_transp: got %b need 0", rsp_transp); end
    endtask

    // Starts in reset; the grant is issued in the first cycle after release.
    task automatic test_single();
        @(negedge Clk);
        Reset_n  = 1'b1;
        req      = 4'b0001;
        req_addr = {19'd7, 19'd6, 19'd5, 19'd5};
        #1;
        n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b need 0001", grant); end
        n_chk++; if (rom_addr !== 19'd5) begin n_fail++; $display("FAIL single_rom_addr: got %0d need 5", rom_addr); end
        @(negedge Clk);
        req = 4'b0000;
        #1;
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b need 0", rsp_valid); end
        @(negedge Clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b need 1", rsp_valid); end
        n_chk++; if (rsp_id !== 3'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d need 0", rsp_id); end
        n_chk++; if (rsp_data !== 24'h123456) begin n_fail++; $display("FAIL single_rsp_data: got %h need 123456", rsp_data); end
        n_chk++; if (rsp_transp !== 1'b0) begin n_fail++; $display("FAIL single_rsp_transp: got %b need 0", rsp_transp); end
        @(negedge Clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_shot: got %b need 0", rsp_valid); end
        n_chk++; if (rsp_data !== 24'h123456) begin n_fail++; $display("FAIL single_hold_data: got %h need 123456", rsp_data); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_g;
        int         id;
        do_reset();
        req_addr = {19'd19, 19'd18, 19'd17, 19'd16};
        for (int c = 0; c < 11; c++) begin
            @(negedge Clk);
            req = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_g = (c < 8) ? g_tab[c % 4] : 4'b0000;
            n_chk++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant c%0d: got %b need %b", c, grant, exp_g); end
            if (c < 8) begin
                n_chk++; if (rom_addr !== 19'(16 + c % 4)) begin n_fail++; $display("FAIL rr_rom_addr c%0d: got %0d need %0d", c, rom_addr, 16 + c % 4); end
            end
            if (c >= 2 && c < 10) begin
                id = (c - 2) % 4;
                n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_rsp_valid c%0d: got %b need 1", c, rsp_valid); end
                n_chk++; if (rsp_id !== 3'(id)) begin n_fail++; $display("FAIL rr_rsp_id c%0d: got %0d need %0d", c, rsp_id, id); end
                n_chk++; if (rsp_data !== exp_pix(19'(16 + id))) begin n_fail++; $display("FAIL rr_rsp_data c%0d: got %h need %h", c, rsp_data, exp_pix(19'(16 + id))); end
                n_chk++; if (rsp_transp !== 1'b0) begin n_fail++; $display("FAIL rr_rsp_transp c%0d: got %b need 0", c, rsp_transp); end
            end else begin
                n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_rsp_idle c%0d: got %b need 0", c, rsp_valid); end
            end
        end
    endtask

    task automatic test_transparency();
        do_reset();
        @(negedge Clk);
        req      = 4'b0100;
        req_addr = {19'd1, 19'd9, 19'd1, 19'd1};
        #1;
        n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL transp_grant: got %b need 0100", grant); end
        n_chk++; if (rom_addr !== 19'd9) begin n_fail++; $display("FAIL transp_rom_addr: got %0d need 9", rom_addr); end
        @(negedge Clk);
        req = 4'b0000;
        @(negedge Clk);
        #1;
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL transp_rsp_valid: got %b need 1", rsp_valid); end
        n_chk++; if (rsp_id !== 3'd2) begin n_fail++; $display("FAIL transp_rsp_id: got %0d need 2", rsp_id); end
        n_chk++; if (rsp_data !== 24'hFF00FF) begin n_fail++; $display("FAIL transp_rsp_data: got %h need ff00ff", rsp_data); end
        n_chk++; if (rsp_transp !== 1'b1) begin n_fail++; $display("FAIL transp_flag: got %b need 1", rsp_transp); end
        @(negedge Clk);
        #1;
        n_chk++; if (rsp_transp !== 1'b0) begin n_fail++; $display("FAIL transp_flag_idle: got %b need 0", rsp_transp); end
    endtask

    task automatic test_enable();
        logic       en_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] rq_tab [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
        logic [3:0] g_tab  [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic       rv_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] id_tab [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        do_reset();
        req_addr = {19'd35, 19'd34, 19'd33, 19'd32};
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            en  = en_tab[c];
            req = rq_tab[c];
            #1;
            n_chk++; if (grant !== g_tab[c]) begin n_fail++; $display("FAIL en_grant c%0d: got %b need %b", c, grant, g_tab[c]); end
            n_chk++; if (rsp_valid !== rv_tab[c]) begin n_fail++; $display("FAIL en_rsp_valid c%0d: got %b need %b", c, rsp_valid, rv_tab[c]); end
            if (rv_tab[c]) begin
                n_chk++; if (rsp_id !== id_tab[c]) begin n_fail++; $display("FAIL en_rsp_id c%0d: got %0d need %0d", c, rsp_id, id_tab[c]); end
                n_chk++; if (rsp_data !== exp_pix(19'(32 + id_tab[c]))) begin n_fail++; $display("FAIL en_rsp_data c%0d: got %h need %h", c, rsp_data, exp_pix(19'(32 + id_tab[c]))); end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic       rn_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] rq_tab [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0000};
        logic [3:0] g_tab  [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        logic       rv_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        req_addr = {19'd23, 19'd22, 19'd21, 19'd20};
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            Reset_n = rn_tab[c];
            req     = rq_tab[c];
            #1;
            n_chk++; if (grant !== g_tab[c]) begin n_fail++; $display("FAIL rstmid_grant c%0d: got %b need %b", c, grant, g_tab[c]); end
            n_chk++; if (rsp_valid !== rv_tab[c]) begin n_fail++; $display("FAIL rstmid_rsp_valid c%0d: got %b need %b", c, rsp_valid, rv_tab[c]); end
        end
        n_chk++; if (rsp_id !== 3'd0 || rsp_data !== exp_pix(19'd20)) begin n_fail++; $display("FAIL rstmid_rsp: got id %0d data %h need id 0 data %h", rsp_id, rsp_data, exp_pix(19'd20)); end
    endtask

    task automatic test_wrap_sparse();
        logic [3:0] rq_tab [11] = '{4'b0100, 4'b0101, 4'b0101, 4'b0000, 4'b1111, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] g_tab  [11] = '{4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b1000, 4'b0010,
                                   4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic       rv_tab [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] id_tab [11] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd3, 3'd1, 3'd1, 3'd1, 3'd0};
        do_reset();
        req_addr = {19'd43, 19'd42, 19'd41, 19'd40};
        for (int c = 0; c < 11; c++) begin
            @(negedge Clk);
            req = rq_tab[c];
            #1;
            n_chk++; if (grant !== g_tab[c]) begin n_fail++; $display("FAIL wrap_grant c%0d: got %b need %b", c, grant, g_tab[c]); end
            n_chk++; if (rsp_valid !== rv_tab[c]) begin n_fail++; $display("FAIL wrap_rsp_valid c%0d: got %b need %b", c, rsp_valid, rv_tab[c]); end
            if (rv_tab[c]) begin
                n_chk++; if (rsp_id !== id_tab[c]) begin n_fail++; $display("FAIL wrap_rsp_id c%0d: got %0d need %0d", c, rsp_id, id_tab[c]); end
                n_chk++; if (rsp_data !== exp_pix(19'(40 + id_tab[c]))) begin n_fail++; $display("FAIL wrap_rsp_data c%0d: got %h need %h", c, rsp_data, exp_pix(19'(40 + id_tab[c]))); end
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] rq_tab [5] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] g_tab  [5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic       rv_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        req_addr = {19'd51, 19'd50, 19'd49, 19'd48};
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            req = rq_tab[c];
            #1;
            n_chk++; if (grant !== g_tab[c]) begin n_fail++; $display("FAIL withdraw_grant c%0d: got %b need %b", c, grant, g_tab[c]); end
            n_chk++; if (rsp_valid !== rv_tab[c]) begin n_fail++; $display("FAIL withdraw_rsp_valid c%0d: got %b need %b", c, rsp_valid, rv_tab[c]); end
            if (rv_tab[c]) begin
                n_chk++; if (rsp_id !== 3'd0) begin n_fail++; $display("FAIL withdraw_rsp_id c%0d: got %0d need 0", c, rsp_id); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_transparency();
        test_enable();
        test_reset_midflight();
        test_wrap_sparse();
        test_withdraw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
